// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, N controllers onto one peripheral bus (optional ack timeout: WB_RR_ARBITER_TIMEOUT_EN)
module wb_rr_arbiter #(
    parameter int N       = 2,
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    m_stb,
    input  logic [N-1:0]    m_we,
    input  logic [N*AW-1:0] m_adr,
    input  logic [N*DW-1:0] m_dat_c,
    output logic [DW-1:0]   m_dat_p,
    output logic [N-1:0]    m_ack,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_c,
    input  logic [DW-1:0]   s_dat_p,
    input  logic            s_ack,
    output logic            timeout_err
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] grant, last, pick, idx;
    logic          found, finish, expire;

    // first requester scanning upward from the one after the last winner
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last) + k) % N);
            if (!found && m_stb[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    logic [15:0] cnt;

    // abort when the peripheral has not acked for TIMEOUT busy cycles; a same-edge ack wins
    always_comb expire = state == BUSY && !s_ack && cnt == 16'(TIMEOUT - 1);

    // wait counter and one-cycle error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt         <= (state == BUSY && !s_ack) ? cnt + 16'd1 : '0;
            timeout_err <= expire;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;

    // without the timeout a busy transaction waits for its ack forever
    always_comb expire = 1'b0;
`endif

    // next state; DONE always returns to IDLE so stale strobes are never seen
    always_comb begin
        finish   = state == BUSY && (s_ack || expire);
        state_nx = state == IDLE ? (found ? BUSY : IDLE) :
                   state == BUSY ? (finish ? DONE : BUSY) : IDLE;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // grant capture, registered peripheral side and one-hot ack pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= '0;
            last    <= IW'(N - 1);
            s_stb   <= 1'b0;
            s_we    <= 1'b0;
            s_adr   <= '0;
            s_dat_c <= '0;
            m_ack   <= '0;
            m_dat_p <= '0;
        end else begin
            m_ack <= '0;
            if (state == IDLE && found) begin
                grant   <= pick;
                s_stb   <= 1'b1;
                s_we    <= m_we[pick];
                s_adr   <= m_adr[pick*AW +: AW];
                s_dat_c <= m_dat_c[pick*DW +: DW];
            end
            if (finish) begin
                s_stb   <= 1'b0;
                m_ack   <= N'(1) << grant;
                m_dat_p <= expire ? '1 : s_dat_p;
                last    <= grant;
            end
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed self-checking bench for wb_rr_arbiter (timeout tests with WB_RR_ARBITER_TIMEOUT_EN)
module tb_wb_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] m_stb = '0;
    logic [1:0] m_we = '0;
    logic [7:0] m_adr = '0;
    logic [15:0] m_dat_c = '0;
    logic [7:0] m_dat_p;
    logic [1:0] m_ack;
    logic       s_stb;
    logic       s_we;
    logic [3:0] s_adr;
    logic [7:0] s_dat_c;
    logic [7:0] s_dat_p = '0;
    logic       s_ack = 1'b0;
    logic       timeout_err;
    int         tests = 0;
    int         fails = 0;

    wb_rr_arbiter #(.N(2), .AW(4), .DW(8), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_c(m_dat_c), .m_dat_p(m_dat_p), .m_ack(m_ack), .s_stb(s_stb),
        .s_we(s_we), .s_adr(s_adr), .s_dat_c(s_dat_c), .s_dat_p(s_dat_p),
        .s_ack(s_ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (s_stb !== 1'b0) begin fails++; $display("FAIL reset_s_stb: got %0h want 0", s_stb); end
        tests++; if (m_ack !== 2'b00) begin fails++; $display("FAIL reset_m_ack: got %0h want 0", m_ack); end
        tests++; if (m_dat_p !== 8'h00) begin fails++; $display("FAIL reset_m_dat_p: got %0h want 0", m_dat_p); end
        tests++; if (s_adr !== 4'h0) begin fails++; $display("FAIL reset_s_adr: got %0h want 0", s_adr); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %0h want 0", timeout_err); end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        m_stb = 2'b01;
        m_we  = 2'b00;
        m_adr = 8'h03;
        tick();
        tests++; if (s_stb !== 1'b1 || s_adr !== 4'h3 || s_we !== 1'b0) begin fails++; $display("FAIL read_grant: got stb=%0h adr=%0h we=%0h want 1 3 0", s_stb, s_adr, s_we); end
        tick();
        tick();
        s_ack   = 1'b1;
        s_dat_p = 8'hA5;
        tick();
        tests++; if (m_ack !== 2'b01) begin fails++; $display("FAIL read_ack: got %0h want 1", m_ack); end
        tests++; if (m_dat_p !== 8'hA5) begin fails++; $display("FAIL read_data: got %0h want a5", m_dat_p); end
        tests++; if (s_stb !== 1'b0) begin fails++; $display("FAIL read_stb_drop: got %0h want 0", s_stb); end
        s_ack = 1'b0;
        m_stb = 2'b00;
        tick();
        tests++; if (m_ack !== 2'b00 || m_dat_p !== 8'hA5) begin fails++; $display("FAIL read_ack_pulse: got ack=%0h dat=%0h want 0 a5", m_ack, m_dat_p); end
    endtask

    task automatic test_round_robin();
        int g;
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        m_adr = 8'h21;
        m_stb = 2'b11;
        for (int t = 0; t < 4; t++) begin
            g = t % 2;
            for (int i = 0; i < 10 && s_stb !== 1'b1; i++) tick();
            tests++; if (s_stb !== 1'b1) begin fails++; $display("FAIL rr_wait_%0d: got stb=%0h want 1", t, s_stb); end
            tests++; if (s_adr !== 4'(g + 1)) begin fails++; $display("FAIL rr_order_%0d: got adr=%0h want %0h", t, s_adr, g + 1); end
            s_ack   = 1'b1;
            s_dat_p = 8'(t);
            tick();
            s_ack = 1'b0;
            tests++; if (m_ack !== 2'(1 << g)) begin fails++; $display("FAIL rr_ack_%0d: got %0h want %0h", t, m_ack, 1 << g); end
            tick();
            tests++; if (s_stb !== 1'b0 || m_ack !== 2'b00) begin fails++; $display("FAIL rr_done_%0d: got stb=%0h ack=%0h want 0 0", t, s_stb, m_ack); end
        end
        m_stb = 2'b00;
        tick();
    endtask

    task automatic test_queued_write();
        m_stb   = 2'b01;
        m_we    = 2'b00;
        m_adr   = 8'h01;
        tick();
        m_stb   = 2'b11;
        m_we    = 2'b10;
        m_adr   = 8'h71;
        m_dat_c = 16'h3C00;
        tick();
        tests++; if (s_adr !== 4'h1 || s_we !== 1'b0) begin fails++; $display("FAIL qw_busy_hold: got adr=%0h we=%0h want 1 0", s_adr, s_we); end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m_stb = 2'b10;
        tests++; if (m_ack !== 2'b01) begin fails++; $display("FAIL qw_first_ack: got %0h want 1", m_ack); end
        tick();
        tests++; if (s_stb !== 1'b0) begin fails++; $display("FAIL qw_done_gap: got stb=%0h want 0", s_stb); end
        tick();
        tests++; if (s_stb !== 1'b1 || s_adr !== 4'h7 || s_dat_c !== 8'h3C || s_we !== 1'b1) begin fails++; $display("FAIL qw_write: got stb=%0h adr=%0h dat=%0h we=%0h want 1 7 3c 1", s_stb, s_adr, s_dat_c, s_we); end
        s_ack   = 1'b1;
        s_dat_p = 8'h55;
        tick();
        s_ack = 1'b0;
        m_stb = 2'b00;
        tests++; if (m_ack !== 2'b10 || m_dat_p !== 8'h55) begin fails++; $display("FAIL qw_write_ack: got ack=%0h dat=%0h want 2 55", m_ack, m_dat_p); end
        tick();
    endtask

    task automatic test_spurious_and_reset();
        s_ack = 1'b1;
        tick();
        tick();
        s_ack = 1'b0;
        tests++; if (m_ack !== 2'b00 || s_stb !== 1'b0) begin fails++; $display("FAIL spurious_ack: got ack=%0h stb=%0h want 0 0", m_ack, s_stb); end
        m_we  = 2'b00;
        m_adr = 8'h75;
        m_stb = 2'b10;
        tick();
        tests++; if (s_stb !== 1'b1 || s_adr !== 4'h7) begin fails++; $display("FAIL mid_busy_grant: got stb=%0h adr=%0h want 1 7", s_stb, s_adr); end
        rst = 1'b1;
        tick();
        tests++; if (s_stb !== 1'b0 || m_ack !== 2'b00) begin fails++; $display("FAIL mid_busy_reset: got stb=%0h ack=%0h want 0 0", s_stb, m_ack); end
        rst   = 1'b0;
        m_stb = 2'b11;
        tick();
        tests++; if (s_stb !== 1'b1 || s_adr !== 4'h5) begin fails++; $display("FAIL post_reset_winner: got stb=%0h adr=%0h want 1 5", s_stb, s_adr); end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        m_stb = 2'b00;
        tests++; if (m_ack !== 2'b01) begin fails++; $display("FAIL post_reset_ack: got %0h want 1", m_ack); end
        tick();
    endtask

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        m_we  = 2'b00;
        m_adr = 8'h02;
        m_stb = 2'b01;
        tick();
        tests++; if (s_stb !== 1'b1) begin fails++; $display("FAIL to_grant: got %0h want 1", s_stb); end
        for (int i = 1; i < 8; i++) begin
            tick();
            tests++; if (m_ack !== 2'b00 || timeout_err !== 1'b0) begin fails++; $display("FAIL to_early_%0d: got ack=%0h err=%0h want 0 0", i, m_ack, timeout_err); end
        end
        tick();
        tests++; if (m_ack !== 2'b01 || m_dat_p !== 8'hFF || timeout_err !== 1'b1) begin fails++; $display("FAIL to_abort: got ack=%0h dat=%0h err=%0h want 1 ff 1", m_ack, m_dat_p, timeout_err); end
        m_stb = 2'b00;
        tick();
        tests++; if (timeout_err !== 1'b0 || m_ack !== 2'b00) begin fails++; $display("FAIL to_pulse: got err=%0h ack=%0h want 0 0", timeout_err, m_ack); end
        m_stb = 2'b10;
        tick();
        s_ack   = 1'b1;
        s_dat_p = 8'h12;
        tick();
        s_ack = 1'b0;
        m_stb = 2'b00;
        tests++; if (m_ack !== 2'b10 || m_dat_p !== 8'h12 || timeout_err !== 1'b0) begin fails++; $display("FAIL to_recover: got ack=%0h dat=%0h err=%0h want 2 12 0", m_ack, m_dat_p, timeout_err); end
        tick();
    endtask

    task automatic test_timeout_race();
        m_stb = 2'b01;
        tick();
        for (int i = 1; i < 8; i++) tick();
        s_ack   = 1'b1;
        s_dat_p = 8'h77;
        tick();
        s_ack = 1'b0;
        m_stb = 2'b00;
        tests++; if (m_ack !== 2'b01 || m_dat_p !== 8'h77 || timeout_err !== 1'b0) begin fails++; $display("FAIL to_race: got ack=%0h dat=%0h err=%0h want 1 77 0", m_ack, m_dat_p, timeout_err); end
        tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_queued_write();
        test_spurious_and_reset();
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        test_timeout();
        test_timeout_race();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
